// File: rtl/float_intm.sv
// float_intm: sequential IEEE-754 single-precision to signed 16-bit integer
// converter. Rounds to nearest with ties away from zero and saturates
// out-of-range operands.
//
// Handshake: start_trig is a one-cycle request that is honoured only while
// the FSM is idle (busy = 0). Requests that arrive while busy are dropped,
// not queued. done pulses for exactly one cycle three edges after the
// accepting edge. result_int, ovf and nan_flag change only with done and
// hold their values until the next completion.
//
// Ports:
//   clk_sys     in   system clock, rising edge
//   rst_sys_n   in   asynchronous active-low reset
//   start_trig  in   conversion request, sampled only in IDLE
//   data_float  in   [31:0] IEEE-754 single operand, sampled with start_trig
//   result_int  out  [15:0] two's-complement result
//   done        out  one-cycle completion pulse
//   busy        out  high whenever the FSM is not in IDLE
//   ovf         out  saturation occurred
//   nan_flag    out  operand was NaN
module float_intm (
  input  logic        clk_sys,
  input  logic        rst_sys_n,
  input  logic        start_trig,
  input  logic [31:0] data_float,
  output logic [15:0] result_int,
  output logic        done,
  output logic        busy,
  output logic        ovf,
  output logic        nan_flag
);

  typedef enum logic [1:0] {IDLE, UNPACK, ALIGN, ROUND} state_t;
  typedef enum logic [1:0] {CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN} cls_t;

  localparam logic [31:0] NEG_32768 = 32'hC700_0000;

  state_t state, state_nx;

  // Operand and intermediate pipeline registers
  logic [31:0]       op_q;
  cls_t              cls_q;
  logic              sign_q;
  logic [23:0]       mant_q;
  logic signed [8:0] exp_q;   // unbiased exponent, -126..127
  logic [15:0]       mag_q;
  logic              rnd_q;
  logic              large_q;

  // ---------------- FSM ----------------
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) state <= IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_trig) state_nx = UNPACK;
      UNPACK:  state_nx = ALIGN;
      ALIGN:   state_nx = ROUND;
      ROUND:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // ---------------- UNPACK: field split and classification ----------------
  logic [7:0]  e_fld;
  logic [22:0] f_fld;
  cls_t        cls_nx;

  assign e_fld = op_q[30:23];
  assign f_fld = op_q[22:0];

  always_comb begin
    cls_nx = CLS_NORM;
    if (e_fld == 8'hFF)      cls_nx = (f_fld != 23'd0) ? CLS_NAN : CLS_INF;
    else if (e_fld == 8'h00) cls_nx = CLS_ZERO;   // denormals flush to zero
  end

  // ---------------- ALIGN: integer magnitude and round bit ----------------
  logic [15:0] mag_nx;
  logic        rnd_nx;
  logic        large_nx;
  logic [4:0]  sh_amt;
  logic [4:0]  rnd_idx;
  logic [23:0] mant_sh;

  always_comb begin
    mag_nx   = 16'd0;
    rnd_nx   = 1'b0;
    large_nx = 1'b0;
    sh_amt   = 5'(9'sd23 - exp_q);
    rnd_idx  = 5'(9'sd22 - exp_q);
    mant_sh  = mant_q >> sh_amt;
    if (exp_q < -9'sd1) begin
      mag_nx = 16'd0;
      rnd_nx = 1'b0;
    end else if (exp_q == -9'sd1) begin
      mag_nx = 16'd0;
      rnd_nx = 1'b1;
    end else if (exp_q <= 9'sd14) begin
      // At most 15 significant bits survive a shift of 9 or more
      mag_nx = mant_sh[15:0];
      rnd_nx = mant_q[rnd_idx];
    end else begin
      large_nx = 1'b1;
    end
  end

  // ---------------- ROUND: rounding, sign and saturation ----------------
  logic [16:0] rnd_mag;
  logic [15:0] res_nx;
  logic        ovf_nx;
  logic        nan_nx;

  assign rnd_mag = 17'(mag_q) + 17'(rnd_q);

  always_comb begin
    res_nx = 16'h0000;
    ovf_nx = 1'b0;
    nan_nx = 1'b0;
    case (cls_q)
      CLS_NAN: nan_nx = 1'b1;
      CLS_INF: begin
        res_nx = sign_q ? 16'h8000 : 16'h7FFF;
        ovf_nx = 1'b1;
      end
      CLS_ZERO: res_nx = 16'h0000;
      default: begin
        if (!sign_q) begin
          if (large_q || rnd_mag > 17'd32767) begin
            res_nx = 16'h7FFF;
            ovf_nx = 1'b1;
          end else begin
            res_nx = rnd_mag[15:0];
          end
        end else begin
          if (large_q) begin
            // -32768.0 is the only large operand that is representable
            res_nx = 16'h8000;
            ovf_nx = (op_q != NEG_32768);
          end else if (rnd_mag > 17'd32768) begin
            res_nx = 16'h8000;
            ovf_nx = 1'b1;
          end else begin
            // r = 32768 negates to 0x8000; r = 0 negates to 0x0000
            res_nx = (~rnd_mag[15:0]) + 16'd1;
          end
        end
      end
    endcase
  end

  // ---------------- Datapath registers ----------------
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      op_q    <= 32'd0;
      cls_q   <= CLS_ZERO;
      sign_q  <= 1'b0;
      mant_q  <= 24'd0;
      exp_q   <= 9'sd0;
      mag_q   <= 16'd0;
      rnd_q   <= 1'b0;
      large_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_trig) op_q <= data_float;
        UNPACK: begin
          cls_q  <= cls_nx;
          sign_q <= op_q[31];
          mant_q <= {1'b1, f_fld};
          exp_q  <= $signed({1'b0, e_fld}) - 9'sd127;
        end
        ALIGN: begin
          mag_q   <= mag_nx;
          rnd_q   <= rnd_nx;
          large_q <= large_nx;
        end
        default: ;
      endcase
    end
  end

  // ---------------- Outputs: written only on ROUND -> IDLE ----------------
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      result_int <= 16'h0000;
      ovf        <= 1'b0;
      nan_flag   <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= (state == ROUND);
      if (state == ROUND) begin
        result_int <= res_nx;
        ovf        <= ovf_nx;
        nan_flag   <= nan_nx;
      end
    end
  end

endmodule

// File: tb/tb_float_intm.sv
// Self-checking bench for float_intm. A real-arithmetic reference model
// predicts each accepted conversion; a per-cycle monitor compares done,
// busy, result_int, ovf and nan_flag against the prediction.
module tb_float_intm;

  logic        clk_sys;
  logic        rst_sys_n;
  logic        start_trig;
  logic [31:0] data_float;
  logic [15:0] result_int;
  logic        done;
  logic        busy;
  logic        ovf;
  logic        nan_flag;

  float_intm dut (
    .clk_sys   (clk_sys),
    .rst_sys_n (rst_sys_n),
    .start_trig(start_trig),
    .data_float(data_float),
    .result_int(result_int),
    .done      (done),
    .busy      (busy),
    .ovf       (ovf),
    .nan_flag  (nan_flag)
  );

  // ---------------- clock ----------------
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;        // number of rising edges seen so far
  int          free_at = 0;    // first edge at which a request is accepted
  int          busy_from = 0;
  int          busy_to = 0;
  logic [17:0] exp_q[$];       // {nan_flag, ovf, result_int}
  int          due_q[$];       // edge at which done must appear
  logic [17:0] held = 18'd0;   // outputs expected to be held

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: value from the IEEE fields in real arithmetic, then
  // round-half-away and saturate. Returns {nan, ovf, result}.
  function automatic logic [17:0] model(input logic [31:0] x);
    int          e;
    logic [22:0] f;
    logic        s;
    real         p, a;
    int          r;
    logic [15:0] res;
    s = x[31];
    e = int'(x[30:23]);
    f = x[22:0];
    if (e == 255 && f != 0) return {1'b1, 1'b0, 16'h0000};
    if (e == 255)           return s ? {2'b01, 16'h8000} : {2'b01, 16'h7FFF};
    if (e == 0)             return 18'd0;
    p = 1.0;
    if (e >= 127) for (int i = 0; i < e - 127; i++) p = p * 2.0;
    else          for (int i = 0; i < 127 - e; i++) p = p / 2.0;
    a = (1.0 + real'(f) / 8388608.0) * p + 0.5;   // floor(a) is |result|
    if (!s && a >= 32768.0) return {2'b01, 16'h7FFF};
    if (s && a >= 32769.0)  return {2'b01, 16'h8000};
    r = $rtoi(a);
    res = s ? 16'(-r) : 16'(r);
    return {2'b00, res};
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(posedge clk_sys) begin
    logic exp_done;
    logic exp_busy;
    #1;
    cyc++;
    exp_done = (due_q.size() > 0) && (due_q[0] == cyc);
    if (exp_done) begin
      held = exp_q.pop_front();
      void'(due_q.pop_front());
    end
    exp_busy = (cyc >= busy_from) && (cyc < busy_to);
    chk("done", 32'(done), 32'(exp_done));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("result_int", 32'(result_int), 32'(held[15:0]));
    chk("ovf", 32'(ovf), 32'(held[16]));
    chk("nan_flag", 32'(nan_flag), 32'(held[17]));
  end

  // ---------------- driver ----------------
  // Occupies one cycle: drives inputs at the falling edge before the next
  // rising edge, and records the prediction if that edge accepts the request.
  task automatic drive_cycle(input logic st, input logic [31:0] x);
    int t0;
    @(negedge clk_sys);
    start_trig = st;
    data_float = x;
    t0 = cyc + 1;
    if (st && t0 >= free_at) begin
      exp_q.push_back(model(x));
      due_q.push_back(t0 + 3);
      free_at   = t0 + 4;
      busy_from = t0;
      busy_to   = t0 + 3;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, $urandom);
  endtask

  // ---------------- directed vectors: {nan, ovf, result} ----------------
  localparam int NV = 16;
  logic [31:0] vin [NV] = '{
    32'h4116_0000, 32'hC020_0000, 32'h3F00_0000, 32'h3EFF_FFFF,
    32'h0000_0001, 32'h46FF_FE00, 32'h46FF_FFFF, 32'hC700_0000,
    32'hC700_0080, 32'h7FC0_0000, 32'h7F80_0000, 32'hFF80_0000,
    32'h8000_0000, 32'h3FC0_0000, 32'hC6FF_FF00, 32'h4700_0000
  };
  logic [17:0] vexp [NV] = '{
    18'h0_0009, 18'h0_FFFD, 18'h0_0001, 18'h0_0000,
    18'h0_0000, 18'h0_7FFF, 18'h1_7FFF, 18'h0_8000,
    18'h1_8000, 18'h2_0000, 18'h1_7FFF, 18'h1_8000,
    18'h0_0000, 18'h0_0002, 18'h0_8000, 18'h1_7FFF
  };

  initial begin
    rst_sys_n  = 1'b0;
    start_trig = 1'b0;
    data_float = 32'd0;
    repeat (2) @(negedge clk_sys);
    chk("reset_result", 32'(result_int), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    rst_sys_n = 1'b1;
    idle(2);

    // Model pinned against hand-computed values; DUT checked by the monitor
    for (int i = 0; i < NV; i++) begin
      chk($sformatf("model_%08h", vin[i]), 32'(model(vin[i])), 32'(vexp[i]));
      drive_cycle(1'b1, vin[i]);
      idle(4);
    end

    // Requests at T0+2 and T0+3 are dropped; T0+4 is accepted
    chk("model_5.0", 32'(model(32'h40A0_0000)), 32'h0_0005);
    chk("model_10.0", 32'(model(32'h4120_0000)), 32'h0_000A);
    drive_cycle(1'b1, 32'h40A0_0000);
    drive_cycle(1'b0, 32'h4120_0000);
    drive_cycle(1'b1, 32'h4120_0000);
    drive_cycle(1'b1, 32'h4120_0000);
    drive_cycle(1'b1, 32'h4120_0000);
    idle(6);

    // Reset after edge T0+1 aborts the conversion with no done
    drive_cycle(1'b1, 32'h4116_0000);
    drive_cycle(1'b0, 32'h0);
    @(negedge clk_sys);
    rst_sys_n = 1'b0;
    exp_q.delete();
    due_q.delete();
    held = 18'd0;
    busy_to = 0;
    free_at = 0;
    #1;
    chk("arst_result", 32'(result_int), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_done", 32'(done), 32'h0);
    chk("arst_ovf", 32'(ovf), 32'h0);
    chk("arst_nan", 32'(nan_flag), 32'h0);
    repeat (2) @(negedge clk_sys);
    rst_sys_n = 1'b1;
    idle(1);
    chk("model_-9.375", 32'(model(32'hC116_0000)), 32'h0_FFF7);
    drive_cycle(1'b1, 32'hC116_0000);
    idle(6);

    chk("pending_done", 32'(due_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound on run time
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
